// File: rtl/mem_pkg.sv
// Encodings and default geometry shared by fetch, the memory stage and both memories.
package mem_pkg;
    localparam logic [1:0]  ACCESS_BYTE    = 2'b00;
    localparam logic [1:0]  ACCESS_HALF    = 2'b01;
    localparam logic [1:0]  ACCESS_WORD    = 2'b11;
    localparam logic [1:0]  ACCESS_RSVD    = 2'b10;
    localparam logic [31:0] DEFAULT_OFFSET = 32'h80020000;
    localparam int          DEFAULT_DEPTH  = 1048576;
endpackage

// File: rtl/mem_access_check.sv
// Combinational request decode: access size in bytes, array index, and the reject flag
// for out-of-range, misaligned or reserved-size requests.
module mem_access_check
    import mem_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET      = DEFAULT_OFFSET,
    parameter int                     MEMORY_DEPTH  = DEFAULT_DEPTH
) (
    input  logic [0:ADDRESS_WIDTH-1] addr_in,
    input  logic [1:0]               access_size_in,
    output logic [2:0]               size_bytes,
    output logic [ADDRESS_WIDTH-1:0] idx,
    output logic                     reject
);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);

    logic                   misaligned;
    logic                   reserved;
    logic [ADDRESS_WIDTH:0] end_idx;

    always_comb begin
        idx        = addr_in - OFFSET;
        size_bytes = 3'd4;
        misaligned = 1'b0;
        reserved   = 1'b0;
        case (access_size_in)
            ACCESS_BYTE: size_bytes = 3'd1;
            ACCESS_HALF: begin
                size_bytes = 3'd2;
                misaligned = addr_in[ADDRESS_WIDTH-1];
            end
            ACCESS_WORD: misaligned = |addr_in[ADDRESS_WIDTH-2:ADDRESS_WIDTH-1];
            default:     reserved = 1'b1;
        endcase
        // One extra bit so an index near the top of the 32-bit space cannot wrap back into range.
        end_idx = {1'b0, idx} + {{(ADDRESS_WIDTH-2){1'b0}}, size_bytes};
        reject  = reserved || misaligned || (end_idx > DEPTH_EXT);
    end
endmodule

// File: rtl/instruction_memory.sv
// Byte-addressed big-endian memory with a single request port; read data and status
// are registered and appear one cycle after the request.
module instruction_memory
    import mem_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET        = DEFAULT_OFFSET,
    parameter int                       MEMORY_DEPTH  = DEFAULT_DEPTH
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [0:ADDRESS_WIDTH-1] addr_in,
    input  logic                     wren_in,
    input  logic [1:0]               access_size_in,
    input  logic [0:ADDRESS_WIDTH-1] data_in,
    input  logic                     enable_in,
    output logic [0:ADDRESS_WIDTH-1] data_out,
    output logic                     valid_out,
    output logic                     error_out
);
    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    logic [7:0]               mem_q [MEMORY_DEPTH];
    logic [2:0]               size_bytes;
    logic [ADDRESS_WIDTH-1:0] idx;
    logic                     reject;
    logic [IDX_W-1:0]         i0, i1, i2, i3;
    logic [0:ADDRESS_WIDTH-1] rd_word;
    logic                     do_write;
    logic [0:ADDRESS_WIDTH-1] data_d, data_q;
    logic                     valid_d, valid_q, error_d, error_q;
    logic                     unused_idx_hi;

    mem_access_check #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .OFFSET        (OFFSET),
        .MEMORY_DEPTH  (MEMORY_DEPTH)
    ) u_check (
        .addr_in        (addr_in),
        .access_size_in (access_size_in),
        .size_bytes     (size_bytes),
        .idx            (idx),
        .reject         (reject)
    );

    // Only the low index bits address the array; the upper bits only matter to the range check.
    assign unused_idx_hi = ^idx[ADDRESS_WIDTH-1:IDX_W];
    assign i0 = idx[IDX_W-1:0];
    assign i1 = i0 + IDX_W'(1);
    assign i2 = i0 + IDX_W'(2);
    assign i3 = i0 + IDX_W'(3);
    assign do_write = enable_in && wren_in && !reject;

    always_comb begin
        case (size_bytes)
            3'd1:    rd_word = {{(ADDRESS_WIDTH-8){1'b0}}, mem_q[i0]};
            3'd2:    rd_word = {{(ADDRESS_WIDTH-16){1'b0}}, mem_q[i0], mem_q[i1]};
            default: rd_word = {mem_q[i0], mem_q[i1], mem_q[i2], mem_q[i3]};
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        if (enable_in) begin
            valid_d = 1'b1;
            if (reject) begin
                error_d = 1'b1;
                data_d  = '0;
            end else if (!wren_in) begin
                data_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Array is never reset, but a write seen while reset is held is dropped.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && do_write) begin
            case (size_bytes)
                3'd1: mem_q[i0] <= data_in[ADDRESS_WIDTH-8:ADDRESS_WIDTH-1];
                3'd2: begin
                    mem_q[i0] <= data_in[ADDRESS_WIDTH-16:ADDRESS_WIDTH-9];
                    mem_q[i1] <= data_in[ADDRESS_WIDTH-8:ADDRESS_WIDTH-1];
                end
                default: begin
                    mem_q[i0] <= data_in[0:7];
                    mem_q[i1] <= data_in[8:15];
                    mem_q[i2] <= data_in[16:23];
                    mem_q[i3] <= data_in[24:31];
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign error_out = error_q;
endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: sized reads/writes, rejects, range edges and async reset.
module tb_instruction_memory;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic [0:31] addr_in = '0;
    logic        wren_in = 1'b0;
    logic [1:0]  access_size_in = 2'b11;
    logic [0:31] data_in = '0;
    logic        enable_in = 1'b0;
    logic [0:31] data_out;
    logic        valid_out;
    logic        error_out;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] BASE = 32'h80020000;
    localparam logic [31:0] TOP  = 32'h80120000;

    instruction_memory dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .addr_in        (addr_in),
        .wren_in        (wren_in),
        .access_size_in (access_size_in),
        .data_in        (data_in),
        .enable_in      (enable_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .error_out      (error_out)
    );

    always #5 clk_in = ~clk_in;

    // One request cycle: drive, take the edge, return 1 time unit later with enable dropped.
    task automatic issue(input logic [31:0] a, input logic wr, input logic [1:0] sz, input logic [31:0] d);
        addr_in = a; wren_in = wr; access_size_in = sz; data_in = d; enable_in = 1'b1;
        @(posedge clk_in); #1;
        enable_in = 1'b0; wren_in = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h want %h", data_out, 32'h0); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error_out); end
        rst_n_in = 1'b1;
    endtask

    task automatic test_word_rw();
        issue(BASE, 1'b1, 2'b11, 32'h01234567);
        checks++; if (valid_out !== 1'b1 || error_out !== 1'b0) begin errors++; $display("FAIL word_write_status got v=%b e=%b want v=1 e=0", valid_out, error_out); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL word_write_data_hold got %h want %h", data_out, 32'h0); end
        issue(BASE, 1'b0, 2'b11, 32'h0);
        checks++; if (data_out !== 32'h01234567) begin errors++; $display("FAIL word_read got %h want %h", data_out, 32'h01234567); end
        checks++; if (valid_out !== 1'b1 || error_out !== 1'b0) begin errors++; $display("FAIL word_read_status got v=%b e=%b want v=1 e=0", valid_out, error_out); end
    endtask

    task automatic test_sub_word();
        issue(BASE, 1'b0, 2'b00, 32'h0);
        checks++; if (data_out !== 32'h00000001) begin errors++; $display("FAIL byte_read0 got %h want %h", data_out, 32'h00000001); end
        issue(BASE + 3, 1'b0, 2'b00, 32'h0);
        checks++; if (data_out !== 32'h00000067) begin errors++; $display("FAIL byte_read3 got %h want %h", data_out, 32'h00000067); end
        issue(BASE + 2, 1'b0, 2'b01, 32'h0);
        checks++; if (data_out !== 32'h00004567) begin errors++; $display("FAIL half_read2 got %h want %h", data_out, 32'h00004567); end
    endtask

    task automatic test_byte_write();
        issue(BASE + 1, 1'b1, 2'b00, 32'hFFFFFFAB);
        checks++; if (data_out !== 32'h00004567) begin errors++; $display("FAIL byte_write_data_hold got %h want %h", data_out, 32'h00004567); end
        issue(BASE, 1'b0, 2'b11, 32'h0);
        checks++; if (data_out !== 32'h01AB4567) begin errors++; $display("FAIL byte_write_readback got %h want %h", data_out, 32'h01AB4567); end
    endtask

    task automatic test_rejects();
        logic [31:0] addrs [4];
        logic [1:0]  sizes [4];
        logic        wrs   [4];
        addrs = '{BASE + 2, BASE, 32'h8001FFFC, BASE + 2};
        sizes = '{2'b11, 2'b10, 2'b11, 2'b11};
        wrs   = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(addrs[i], wrs[i], sizes[i], 32'hFFFFFFFF);
            checks++;
            if (error_out !== 1'b1 || valid_out !== 1'b1 || data_out !== 32'h0) begin
                errors++;
                $display("FAIL reject_%0d got v=%b e=%b d=%h want v=1 e=1 d=00000000", i, valid_out, error_out, data_out);
            end
        end
        issue(BASE, 1'b0, 2'b11, 32'h0);
        checks++; if (data_out !== 32'h01AB4567) begin errors++; $display("FAIL reject_array_intact got %h want %h", data_out, 32'h01AB4567); end
    endtask

    task automatic test_boundary();
        issue(TOP - 4, 1'b1, 2'b11, 32'hDEADBEEF);
        checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL top_word_write_error got %b want 0", error_out); end
        issue(TOP - 4, 1'b0, 2'b11, 32'h0);
        checks++; if (data_out !== 32'hDEADBEEF || error_out !== 1'b0) begin errors++; $display("FAIL top_word_read got %h e=%b want deadbeef e=0", data_out, error_out); end
        issue(TOP - 2, 1'b0, 2'b01, 32'h0);
        checks++; if (data_out !== 32'h0000BEEF || error_out !== 1'b0) begin errors++; $display("FAIL top_half_read got %h e=%b want 0000beef e=0", data_out, error_out); end
        issue(TOP - 1, 1'b0, 2'b00, 32'h0);
        checks++; if (data_out !== 32'h000000EF || error_out !== 1'b0) begin errors++; $display("FAIL top_byte_read got %h e=%b want 000000ef e=0", data_out, error_out); end
        issue(TOP - 2, 1'b0, 2'b11, 32'h0);
        checks++; if (error_out !== 1'b1 || data_out !== 32'h0) begin errors++; $display("FAIL top_minus2_word got e=%b d=%h want e=1 d=00000000", error_out, data_out); end
        issue(TOP, 1'b0, 2'b11, 32'h0);
        checks++; if (error_out !== 1'b1 || valid_out !== 1'b1) begin errors++; $display("FAIL past_top_word got v=%b e=%b want v=1 e=1", valid_out, error_out); end
        issue(TOP, 1'b0, 2'b00, 32'h0);
        checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL past_top_byte got e=%b want 1", error_out); end
    endtask

    task automatic test_idle();
        issue(BASE + 3, 1'b0, 2'b00, 32'h0);
        @(posedge clk_in); #1;
        checks++; if (valid_out !== 1'b0 || error_out !== 1'b0) begin errors++; $display("FAIL idle_status got v=%b e=%b want v=0 e=0", valid_out, error_out); end
        checks++; if (data_out !== 32'h00000067) begin errors++; $display("FAIL idle_data_hold got %h want %h", data_out, 32'h00000067); end
    endtask

    task automatic test_back_to_back();
        issue(BASE, 1'b1, 2'b01, 32'h0000CAFE);
        issue(BASE, 1'b0, 2'b11, 32'h0);
        checks++; if (data_out !== 32'hCAFE4567) begin errors++; $display("FAIL b2b_read_after_write got %h want %h", data_out, 32'hCAFE4567); end
        issue(BASE + 1, 1'b0, 2'b00, 32'h0);
        checks++; if (data_out !== 32'h000000FE) begin errors++; $display("FAIL b2b_byte1 got %h want %h", data_out, 32'h000000FE); end
        issue(BASE + 2, 1'b0, 2'b11, 32'h0);
        checks++; if (error_out !== 1'b1 || data_out !== 32'h0) begin errors++; $display("FAIL b2b_reject got e=%b d=%h want e=1 d=00000000", error_out, data_out); end
        issue(BASE, 1'b0, 2'b11, 32'h0);
        checks++; if (data_out !== 32'hCAFE4567 || error_out !== 1'b0) begin errors++; $display("FAIL b2b_recover got %h e=%b want cafe4567 e=0", data_out, error_out); end
    endtask

    task automatic test_reset_mid();
        issue(BASE, 1'b0, 2'b11, 32'h0);
        addr_in = BASE + 3; access_size_in = 2'b00; wren_in = 1'b0; enable_in = 1'b1;
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (data_out !== 32'h0 || valid_out !== 1'b0 || error_out !== 1'b0) begin errors++; $display("FAIL async_reset got d=%h v=%b e=%b want all 0", data_out, valid_out, error_out); end
        addr_in = BASE; access_size_in = 2'b11; wren_in = 1'b1; data_in = 32'h11111111;
        @(posedge clk_in); #1;
        checks++; if (valid_out !== 1'b0 || data_out !== 32'h0) begin errors++; $display("FAIL reset_hold got d=%h v=%b want d=00000000 v=0", data_out, valid_out); end
        enable_in = 1'b0; wren_in = 1'b0;
        rst_n_in = 1'b1;
        issue(BASE, 1'b0, 2'b11, 32'h0);
        checks++; if (data_out !== 32'hCAFE4567 || valid_out !== 1'b1) begin errors++; $display("FAIL first_read_after_reset got %h v=%b want cafe4567 v=1", data_out, valid_out); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_sub_word();
        test_byte_write();
        test_rejects();
        test_boundary();
        test_idle();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
